msg_out_buffer: RTL and testbench

//   Elastic buffer directly downstream of the message extractor. Captures each extracted message
//   (256-bit payload, 32-bit right-justified bytemask), converts the mask to a byte length and

---
 rtl/msg_pkg.sv | 32 +++
 rtl/msg_out_buffer_if.sv | 33 +++
 rtl/msg_fifo_mem.sv | 34 +++
 rtl/msg_out_buffer.sv | 119 +++++++++++
 tb/tb_msg_out_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/msg_pkg.sv
// ============================================================================
// Package     : msg_pkg
// Description : Shared widths, entry type and mask-to-length helper for the
//               message output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package msg_pkg;

    localparam int MSG_BYTES  = 32;
    localparam int MSG_LEN_W  = 6;
    localparam int MSG_DATA_W = 256;

    typedef struct packed {
        logic [MSG_LEN_W-1:0]  len;
        logic [MSG_DATA_W-1:0] data;
    } msg_entry_t;

    // Length is the position of the highest set mask bit plus one; zero mask gives zero.
    function automatic logic [MSG_LEN_W-1:0] mask_to_len(input logic [MSG_BYTES-1:0] mask);
        logic [MSG_LEN_W-1:0] len;
        len = '0;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (mask[i]) len = MSG_LEN_W'(i + 1);
        end
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msg_out_buffer_if.sv
// ============================================================================
// Interface   : msg_out_buffer_if
// Description : Extractor-side input beat and consumer-side valid/ready stream
//               of the message output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface msg_out_buffer_if;
    import msg_pkg::*;

    logic                  in_valid;
    logic [MSG_DATA_W-1:0] in_data;
    logic [MSG_BYTES-1:0]  in_bytemask;
    logic                  in_almost_full;
    logic                  out_valid;
    logic                  out_ready;
    logic [MSG_DATA_W-1:0] out_data;
    logic [MSG_LEN_W-1:0]  out_length;

    modport master (
        output in_valid, in_data, in_bytemask, out_ready,
        input  in_almost_full, out_valid, out_data, out_length
    );

    modport slave (
        input  in_valid, in_data, in_bytemask, out_ready,
        output in_almost_full, out_valid, out_data, out_length
    );

endinterface

`default_nettype wire

// File: rtl/msg_fifo_mem.sv
// ============================================================================
// Module      : msg_fifo_mem
// Description : DEPTH x WIDTH storage, one synchronous write port and one
//               asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 262,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/msg_out_buffer.sv
// ============================================================================
// Module      : msg_out_buffer
// Description : Elastic FIFO behind the message extractor; stores each beat
//               with its byte length and replays it left-justified on a
//               show-ahead valid/ready stream. Statistics counters are built
//               only when MSG_OUT_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_out_buffer
    import msg_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic            clk,
    input  logic            reset,
    msg_out_buffer_if.slave bus,
    output logic            overflow,
    output logic [31:0]     stat_msgs,
    output logic [15:0]     stat_drops
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = MSG_LEN_W + MSG_DATA_W;

    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_overflow;

    logic [MSG_LEN_W-1:0] w_len;
    logic                 w_beat;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_drop;
    msg_entry_t           w_wr_entry;
    msg_entry_t           w_head;
    logic [8:0]           w_shamt;

    assign w_len   = mask_to_len(bus.in_bytemask);
    assign w_beat  = bus.in_valid && (w_len != '0);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_rd    = !w_empty && bus.out_ready;
    // A full buffer still accepts a beat when the head is popped in the same cycle.
    assign w_wr    = w_beat && (!w_full || w_rd);
    assign w_drop  = w_beat && w_full && !w_rd;

    assign w_wr_entry = '{len: w_len, data: bus.in_data};

    msg_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (c_EW),
        .AW    (c_AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Shift by 8*(32-len) moves the first message byte to the top byte lane.
    assign w_shamt = {MSG_LEN_W'(MSG_BYTES) - w_head.len, 3'b000};

    assign bus.out_valid      = !w_empty;
    assign bus.out_data       = w_empty ? '0 : (w_head.data << w_shamt);
    assign bus.out_length     = w_empty ? '0 : w_head.len;
    assign bus.in_almost_full = (r_count >= c_CW'(AFULL_LEVEL));
    assign overflow           = r_overflow;

`ifdef MSG_OUT_STATS_EN
    logic [31:0] r_stat_msgs;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_msgs  <= '0;
            r_stat_drops <= '0;
        end else begin
            if (w_wr) r_stat_msgs <= r_stat_msgs + 32'd1;
            if (w_drop && (r_stat_drops != 16'hFFFF)) r_stat_drops <= r_stat_drops + 16'd1;
        end
    end

    assign stat_msgs  = r_stat_msgs;
    assign stat_drops = r_stat_drops;
`else
    assign stat_msgs  = '0;
    assign stat_drops = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_msg_out_buffer.sv
// ============================================================================
// Module      : tb_msg_out_buffer
// Description : Directed self-checking bench for msg_out_buffer (DEPTH=8,
//               AFULL_LEVEL=6); stats expectations follow MSG_OUT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msg_out_buffer;

`ifdef MSG_OUT_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        overflow;
    logic [31:0] stat_msgs;
    logic [15:0] stat_drops;

    int          n_checks;
    int          n_errors;
    int          exp_msgs;
    int          exp_drops;

    msg_out_buffer_if bus ();

    msg_out_buffer #(
        .DEPTH       (8),
        .AFULL_LEVEL (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .overflow   (overflow),
        .stat_msgs  (stat_msgs),
        .stat_drops (stat_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_msgs"},  256'(stat_msgs),  c_STATS ? 256'(exp_msgs)  : 256'd0);
        check_val({tag, "_drops"}, 256'(stat_drops), c_STATS ? 256'(exp_drops) : 256'd0);
    endtask

    // Tagged 8-byte beat: bytes above the mask carry junk that must never reach the output.
    function automatic logic [255:0] tag_data(input int t);
        return {192'hDEAD_BEEF, 64'h1111_2222_0000_0000 | 64'(t)};
    endfunction

    function automatic logic [255:0] tag_out(input int t);
        return {64'h1111_2222_0000_0000 | 64'(t), 192'd0};
    endfunction

    initial begin
        logic [255:0] d;
        n_checks  = 0;
        n_errors  = 0;
        exp_msgs  = 0;
        exp_drops = 0;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_bytemask = '0;
        bus.out_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;

        check_val("rst_out_valid", 256'(bus.out_valid), 256'd0);
        check_val("rst_out_data",  bus.out_data, 256'd0);
        check_val("rst_out_length", 256'(bus.out_length), 256'd0);
        check_val("rst_overflow", 256'(overflow), 256'd0);
        check_val("rst_afull", 256'(bus.in_almost_full), 256'd0);
        check_stats("rst");

        // 6-byte message, out_ready high
        bus.in_valid    = 1'b1;
        bus.in_bytemask = 32'h0000_003F;
        bus.in_data     = {208'hFACE, 48'hA1A2A3A4A5A6};
        bus.out_ready   = 1'b1;
        check_val("t1_no_fallthrough", 256'(bus.out_valid), 256'd0);
        step();
        bus.in_valid = 1'b0;
        exp_msgs++;
        check_val("t1_out_valid", 256'(bus.out_valid), 256'd1);
        check_val("t1_out_length", 256'(bus.out_length), 256'd6);
        check_val("t1_out_data", bus.out_data, {48'hA1A2A3A4A5A6, 208'd0});
        step();
        check_val("t1_empty_after_pop", 256'(bus.out_valid), 256'd0);

        // zero mask is ignored
        bus.in_valid    = 1'b1;
        bus.in_bytemask = 32'h0;
        bus.in_data     = 256'h1234;
        step();
        bus.in_valid = 1'b0;
        check_val("t4_out_valid", 256'(bus.out_valid), 256'd0);
        step();
        check_val("t4_out_valid_later", 256'(bus.out_valid), 256'd0);
        check_stats("t4");

        // 9 beats into 8 entries with consumer stalled
        bus.out_ready   = 1'b0;
        bus.in_bytemask = 32'h0000_00FF;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tag_data(i);
            step();
            if (i < 8) exp_msgs++;
            else exp_drops++;
            check_val($sformatf("t2_afull_%0d", i), 256'(bus.in_almost_full), (i >= 5) ? 256'd1 : 256'd0);
            check_val($sformatf("t2_overflow_%0d", i), 256'(overflow), (i == 8) ? 256'd1 : 256'd0);
        end
        bus.in_valid = 1'b0;
        check_val("t2_stall_length", 256'(bus.out_length), 256'd8);
        check_val("t2_stall_data", bus.out_data, tag_out(0));
        check_stats("t2_full");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t2_drain_valid_%0d", i), 256'(bus.out_valid), 256'd1);
            check_val($sformatf("t2_drain_data_%0d", i), bus.out_data, tag_out(i));
            step();
        end
        check_val("t2_drained", 256'(bus.out_valid), 256'd0);
        check_val("t2_overflow_sticky", 256'(overflow), 256'd1);

        // full buffer with simultaneous read and write
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tag_data(32 + i);
            step();
            exp_msgs++;
        end
        bus.in_data   = tag_data(40);
        bus.out_ready = 1'b1;
        check_val("t3_head_before", bus.out_data, tag_out(32));
        step();
        exp_msgs++;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_val("t3_afull", 256'(bus.in_almost_full), 256'd1);
        check_stats("t3");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t3_drain_valid_%0d", i), 256'(bus.out_valid), 256'd1);
            check_val($sformatf("t3_drain_data_%0d", i), bus.out_data, tag_out(33 + i));
            step();
        end
        check_val("t3_drained", 256'(bus.out_valid), 256'd0);

        // full-width and single-byte messages
        d = 256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20;
        bus.in_valid    = 1'b1;
        bus.in_bytemask = 32'hFFFF_FFFF;
        bus.in_data     = d;
        step();
        bus.in_valid = 1'b0;
        exp_msgs++;
        check_val("t5_len32", 256'(bus.out_length), 256'd32);
        check_val("t5_data32", bus.out_data, d);
        step();
        bus.in_valid    = 1'b1;
        bus.in_bytemask = 32'h0000_0001;
        bus.in_data     = {248'hABCDEF, 8'h5C};
        step();
        bus.in_valid = 1'b0;
        exp_msgs++;
        check_val("t5_len1", 256'(bus.out_length), 256'd1);
        check_val("t5_data1", bus.out_data, {8'h5C, 248'd0});
        step();
        check_val("t5_empty", 256'(bus.out_valid), 256'd0);

        // reset with 4 entries queued
        bus.out_ready   = 1'b0;
        bus.in_bytemask = 32'h0000_00FF;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tag_data(64 + i);
            step();
            exp_msgs++;
        end
        bus.in_valid = 1'b0;
        check_val("t6_pre_valid", 256'(bus.out_valid), 256'd1);
        check_stats("t6_pre");
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_msgs  = 0;
        exp_drops = 0;
        check_val("t6_out_valid", 256'(bus.out_valid), 256'd0);
        check_val("t6_overflow", 256'(overflow), 256'd0);
        check_val("t6_out_data", bus.out_data, 256'd0);
        check_val("t6_afull", 256'(bus.in_almost_full), 256'd0);
        check_stats("t6");
        step();
        check_val("t6_still_empty", 256'(bus.out_valid), 256'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
